// File: rtl/des_key_schedule_rev_if.sv
// des_key_schedule_rev_if: start/key request and round-key valid/ready bus.
// With DES_KEY_SCHED_FWD_EN defined, an encrypt select travels with start.
interface des_key_schedule_rev_if;
    logic        start;
    logic [63:0] key_in;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [47:0] round_key;
    logic [3:0]  rk_index;
    logic        done;
`ifdef DES_KEY_SCHED_FWD_EN
    logic        encrypt;
    modport master (output start, key_in, rk_ready, encrypt, input busy, rk_valid, round_key, rk_index, done);
    modport slave  (input start, key_in, rk_ready, encrypt, output busy, rk_valid, round_key, rk_index, done);
`else
    modport master (output start, key_in, rk_ready, input busy, rk_valid, round_key, rk_index, done);
    modport slave  (input start, key_in, rk_ready, output busy, rk_valid, round_key, rk_index, done);
`endif
endinterface

// File: rtl/des_key_schedule_rev.sv
// des_key_schedule_rev: DES round keys K16..K1 from right rotations of C/D plus PC-2.
// DES_KEY_SCHED_FWD_EN adds an encrypt select giving K1..K16 via left rotations.
module des_key_schedule_rev (
    input logic clk,
    input logic reset,
    des_key_schedule_rev_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int pc1_tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int pc2_tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Tables use FIPS bit numbering, where bit 1 is the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-pc1_tab[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-pc2_tab[i]];
        return r;
    endfunction

    function automatic logic [55:0] rot(input logic [55:0] x, input logic left, input logic one);
        logic [27:0] a;
        logic [27:0] b;
        a = x[55:28];
        b = x[27:0];
        return left ? (one ? {a[26:0], a[27], b[26:0], b[27]} : {a[25:0], a[27:26], b[25:0], b[27:26]})
                    : (one ? {a[0], a[27:1], b[0], b[27:1]} : {a[1:0], a[27:2], b[1:0], b[27:2]});
    endfunction

    state_t      state, state_n;
    logic [55:0] cd, cd_n;
    logic [3:0]  step, step_n;
    logic        done_q, done_n;
    logic        fwd, fwd_in;
    logic [3:0]  ns;
    logic        one;

`ifdef DES_KEY_SCHED_FWD_EN
    logic enc;
    always_ff @(posedge clk or posedge reset)
        if (reset) enc <= 1'b0;
        else if (state == IDLE && bus.start) enc <= bus.encrypt;
    assign fwd    = enc;
    assign fwd_in = bus.encrypt;
`else
    assign fwd    = 1'b0;
    assign fwd_in = 1'b0;
`endif

    // The 15->0 wrap uses a single shift so C/D return to C0/D0 after K1.
    assign ns  = step + 4'd1;
    assign one = ns inside {4'd0, 4'd1, 4'd8, 4'd15};

    always_comb begin
        state_n = state;
        cd_n    = cd;
        step_n  = step;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (bus.start) begin
                state_n = RUN;
                step_n  = 4'd0;
                cd_n    = fwd_in ? rot(pc1(bus.key_in), 1'b1, 1'b1) : pc1(bus.key_in);
            end
        end else if (bus.rk_ready) begin
            step_n = ns;
            cd_n   = rot(cd, fwd, one);
            if (step == 4'd15) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state  <= IDLE;
            cd     <= '0;
            step   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cd     <= cd_n;
            step   <= step_n;
            done_q <= done_n;
        end

    assign bus.busy      = state == RUN;
    assign bus.rk_valid  = state == RUN;
    assign bus.round_key = state == RUN ? pc2(cd) : '0;
    assign bus.rk_index  = state == RUN ? (fwd ? step : ~step) : 4'd0;
    assign bus.done      = done_q;
endmodule
